// File: rtl/ram_bit_pkg.sv
// rtl/ram_bit_pkg.sv - shared opcodes, FSM encoding and bit-modify helper
package ram_bit_pkg;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_BIT_WIDTH  = 6;

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_CLR   = 3'd3;
  localparam logic [2:0] OP_TGL   = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WB   = 1'b1
  } state_t;

  // Operates at the widest supported word; callers zero-extend and truncate.
  function automatic logic [MAX_DATA_WIDTH-1:0] bit_modify(
    input logic [MAX_DATA_WIDTH-1:0] word,
    input logic [MAX_BIT_WIDTH-1:0]  bit_idx,
    input logic [2:0]                op
  );
    logic [MAX_DATA_WIDTH-1:0] mask;
    logic [MAX_DATA_WIDTH-1:0] res;
    mask = {{(MAX_DATA_WIDTH-1){1'b0}}, 1'b1} << bit_idx;
    case (op)
      OP_SET:  res = word | mask;
      OP_CLR:  res = word & ~mask;
      OP_TGL:  res = word ^ mask;
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ram_bit_rmw_if.sv
// rtl/ram_bit_rmw_if.sv - command/response bundle between requester and ram_bit_rmw
interface ram_bit_rmw_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
);
  localparam int BIT_WIDTH = $clog2(DATA_WIDTH);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [BIT_WIDTH-1:0]  cmd_bit;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_bit;
  logic                  cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_bit, cmd_data,
    input  cmd_ready, rd_valid, rd_data, rd_bit, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_bit, cmd_data,
    output cmd_ready, rd_valid, rd_data, rd_bit, cmd_err
  );

endinterface

// File: rtl/ram_bit_sp_mem.sv
// rtl/ram_bit_sp_mem.sv - single-port RAM, one write port, registered read-first output
module ram_bit_sp_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // No reset on the array or read register so the block maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_bit_rmw.sv
// rtl/ram_bit_rmw.sv - word/bit RAM with atomic set/clear/toggle by read-modify-write
module ram_bit_rmw
  import ram_bit_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic           clk,
  input  logic           rst,
  ram_bit_rmw_if.slave   bus
);

  localparam int BIT_WIDTH = $clog2(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BIT_WIDTH-1:0]  bit_q, bit_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  cmd_err_q, cmd_err_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_bit_q, hold_bit_d;

  logic                  accept;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] mod_word;

  ram_bit_sp_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign mod_word = DATA_WIDTH'(bit_modify(MAX_DATA_WIDTH'(mem_rdata),
                                           MAX_BIT_WIDTH'(bit_q), op_q));

  always_comb begin
    accept      = bus.cmd_valid && (state_q == ST_IDLE);
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    bit_d       = bit_q;
    rd_valid_d  = 1'b0;
    cmd_err_d   = 1'b0;
    hold_data_d = hold_data_q;
    hold_bit_d  = hold_bit_q;

    // The RAM output register is live only while rd_valid is high; capture it to hold afterwards.
    if (rd_valid_q) begin
      hold_data_d = mem_rdata;
      hold_bit_d  = mem_rdata[bit_q];
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = bus.cmd_op;
          addr_d = bus.cmd_addr;
          bit_d  = bus.cmd_bit;
          case (bus.cmd_op)
            OP_READ:  rd_valid_d = 1'b1;
            OP_WRITE: rd_valid_d = 1'b0;
            OP_SET, OP_CLR, OP_TGL: begin
              rd_valid_d = 1'b1;
              state_d    = ST_WB;
            end
            default:  cmd_err_d = 1'b1;
          endcase
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Write-back is suppressed under reset so an interrupted RMW leaves memory intact.
    mem_we    = !rst && ((state_q == ST_WB) || (accept && bus.cmd_op == OP_WRITE));
    mem_addr  = (state_q == ST_WB) ? addr_q : bus.cmd_addr;
    mem_wdata = (state_q == ST_WB) ? mod_word : bus.cmd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      bit_q       <= '0;
      rd_valid_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      hold_data_q <= '0;
      hold_bit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      bit_q       <= bit_d;
      rd_valid_q  <= rd_valid_d;
      cmd_err_q   <= cmd_err_d;
      hold_data_q <= hold_data_d;
      hold_bit_q  <= hold_bit_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_valid_q ? mem_rdata : hold_data_q;
  assign bus.rd_bit    = rd_valid_q ? mem_rdata[bit_q] : hold_bit_q;
  assign bus.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_ram_bit_rmw.sv
// tb/tb_ram_bit_rmw.sv - directed vector bench for ram_bit_rmw at 8-bit and 32-bit widths
module tb_ram_bit_rmw;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_bit_rmw_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(11)) bus8 ();
  ram_bit_rmw_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4))  bus32 ();

  ram_bit_rmw #(.DATA_WIDTH(8), .ADDR_WIDTH(11)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  ram_bit_rmw #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  localparam logic [2:0] RD  = 3'd0;
  localparam logic [2:0] WR  = 3'd1;
  localparam logic [2:0] SET = 3'd2;
  localparam logic [2:0] CLR = 3'd3;
  localparam logic [2:0] TGL = 3'd4;
  localparam logic [2:0] RSV = 3'd6;

  typedef struct {
    bit          sel;
    bit          valid;
    logic [2:0]  op;
    logic [10:0] addr;
    logic [4:0]  bidx;
    logic [31:0] data;
    bit          e_ready;
    bit          e_rv;
    logic [31:0] e_data;
    bit          e_bit;
    bit          e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  function automatic void add(bit sel, bit valid, logic [2:0] op, int addr, int bidx,
                              logic [31:0] data, bit e_ready, bit e_rv,
                              logic [31:0] e_data, bit e_bit, bit e_err);
    vec_t v;
    v.sel = sel; v.valid = valid; v.op = op; v.addr = 11'(addr); v.bidx = 5'(bidx);
    v.data = data; v.e_ready = e_ready; v.e_rv = e_rv; v.e_data = e_data;
    v.e_bit = e_bit; v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus8.cmd_valid  = v.valid && !v.sel;
    bus8.cmd_op     = v.op;
    bus8.cmd_addr   = v.addr;
    bus8.cmd_bit    = v.bidx[2:0];
    bus8.cmd_data   = v.data[7:0];
    bus32.cmd_valid = v.valid && v.sel;
    bus32.cmd_op    = v.op;
    bus32.cmd_addr  = v.addr[3:0];
    bus32.cmd_bit   = v.bidx;
    bus32.cmd_data  = v.data;
  endtask

  task automatic check_outs(input bit sel, input int idx, input bit e_ready, input bit e_rv,
                            input logic [31:0] e_data, input bit e_bit, input bit e_err);
    if (sel) begin
      chk("cmd_ready", idx, 32'(bus32.cmd_ready), 32'(e_ready));
      chk("rd_valid",  idx, 32'(bus32.rd_valid),  32'(e_rv));
      chk("rd_data",   idx, bus32.rd_data,         e_data);
      chk("rd_bit",    idx, 32'(bus32.rd_bit),    32'(e_bit));
      chk("cmd_err",   idx, 32'(bus32.cmd_err),   32'(e_err));
    end else begin
      chk("cmd_ready", idx, 32'(bus8.cmd_ready), 32'(e_ready));
      chk("rd_valid",  idx, 32'(bus8.rd_valid),  32'(e_rv));
      chk("rd_data",   idx, 32'(bus8.rd_data),   e_data);
      chk("rd_bit",    idx, 32'(bus8.rd_bit),    32'(e_bit));
      chk("cmd_err",   idx, 32'(bus8.cmd_err),   32'(e_err));
    end
  endtask

  initial begin
    vec_t idle;
    n_pass  = 0;
    n_total = 0;
    idle = '{sel: 1'b0, valid: 1'b0, op: RD, addr: 11'd0, bidx: 5'd0, data: 32'd0,
             e_ready: 1'b1, e_rv: 1'b0, e_data: 32'd0, e_bit: 1'b0, e_err: 1'b0};
    drive(idle);

    // Each row: command presented for one cycle, outputs checked after that edge.
    for (int i = 0; i <= 10; i++) add(0, 1, WR, i, 0, 32'(i + 1), 1, 0, 0, 0, 0);
    for (int i = 0; i <= 10; i++) add(0, 1, RD, i, 0, 0, 1, 1, 32'(i + 1), 1'((i + 1) & 1), 0);
    add(0, 0, RD,  0, 0, 0,        1, 0, 32'd11,   1, 0);
    add(0, 1, WR,  5, 0, 32'h00,   1, 0, 32'd11,   1, 0);
    add(0, 1, SET, 5, 3, 0,        0, 1, 32'h00,   0, 0);
    add(0, 1, WR,  7, 0, 32'h55,   1, 0, 32'h00,   0, 0);
    add(0, 1, RD,  5, 3, 0,        1, 1, 32'h08,   1, 0);
    add(0, 1, WR,  5, 0, 32'hFF,   1, 0, 32'h08,   1, 0);
    add(0, 1, CLR, 5, 7, 0,        0, 1, 32'hFF,   1, 0);
    add(0, 0, RD,  0, 0, 0,        1, 0, 32'hFF,   1, 0);
    add(0, 1, TGL, 5, 0, 0,        0, 1, 32'h7F,   1, 0);
    add(0, 0, RD,  0, 0, 0,        1, 0, 32'h7F,   1, 0);
    add(0, 1, RD,  5, 0, 0,        1, 1, 32'h7E,   0, 0);
    add(0, 1, RD,  7, 0, 0,        1, 1, 32'h08,   0, 0);
    add(0, 1, RSV, 3, 1, 32'hEE,   1, 0, 32'h08,   0, 1);
    add(0, 0, RD,  0, 0, 0,        1, 0, 32'h08,   0, 0);
    add(0, 1, RD,  3, 2, 0,        1, 1, 32'h04,   1, 0);
    add(0, 1, WR,  4, 0, 32'h3C,   1, 0, 32'h04,   1, 0);
    add(0, 1, RD,  4, 5, 0,        1, 1, 32'h3C,   1, 0);
    add(0, 1, SET, 4, 0, 0,        0, 1, 32'h3C,   0, 0);
    add(0, 1, SET, 4, 0, 0,        1, 0, 32'h3C,   0, 0);
    add(0, 1, SET, 4, 0, 0,        0, 1, 32'h3D,   1, 0);
    add(0, 0, RD,  0, 0, 0,        1, 0, 32'h3D,   1, 0);
    add(0, 1, RD,  4, 1, 0,        1, 1, 32'h3D,   0, 0);
    add(1, 1, WR,  15, 0, 32'h8000_0001, 1, 0, 32'h0,         0, 0);
    add(1, 1, SET, 15, 31, 0,            0, 1, 32'h8000_0001, 1, 0);
    add(1, 0, RD,  0,  0,  0,            1, 0, 32'h8000_0001, 1, 0);
    add(1, 1, SET, 15, 31, 0,            0, 1, 32'h8000_0001, 1, 0);
    add(1, 0, RD,  0,  0,  0,            1, 0, 32'h8000_0001, 1, 0);
    add(1, 1, RD,  15, 31, 0,            1, 1, 32'h8000_0001, 1, 0);
    add(1, 1, TGL, 15, 16, 0,            0, 1, 32'h8000_0001, 0, 0);
    add(1, 0, RD,  0,  0,  0,            1, 0, 32'h8000_0001, 0, 0);
    add(1, 1, RD,  15, 16, 0,            1, 1, 32'h8001_0001, 1, 0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outs(0, -1, 1, 0, 32'd0, 0, 0);
    check_outs(1, -1, 1, 0, 32'd0, 0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check_outs(vecs[i].sel, i, vecs[i].e_ready, vecs[i].e_rv, vecs[i].e_data,
                 vecs[i].e_bit, vecs[i].e_err);
    end

    // Reset landing in the write-back cycle must abort the RMW.
    drive('{sel: 1'b0, valid: 1'b1, op: WR, addr: 11'd2, bidx: 5'd0, data: 32'hAA,
            e_ready: 1'b1, e_rv: 1'b0, e_data: 32'd0, e_bit: 1'b0, e_err: 1'b0});
    @(negedge clk);
    drive('{sel: 1'b0, valid: 1'b1, op: SET, addr: 11'd2, bidx: 5'd0, data: 32'h0,
            e_ready: 1'b1, e_rv: 1'b0, e_data: 32'd0, e_bit: 1'b0, e_err: 1'b0});
    @(negedge clk);
    check_outs(0, 100, 0, 1, 32'hAA, 0, 0);
    drive(idle);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outs(0, 101, 1, 0, 32'd0, 0, 0);
    drive('{sel: 1'b0, valid: 1'b1, op: RD, addr: 11'd2, bidx: 5'd0, data: 32'h0,
            e_ready: 1'b1, e_rv: 1'b0, e_data: 32'd0, e_bit: 1'b0, e_err: 1'b0});
    @(negedge clk);
    check_outs(0, 102, 1, 1, 32'hAA, 0, 0);
    drive(idle);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_bit_rmw.md
# ram_bit_rmw

Parametrised single-port RAM with word and single-bit access, successor to the fixed 8-bit word/bit RAM. Supports word read, word write, and atomic bit set/clear/toggle by internal read-modify-write. Every read and RMW returns the addressed word and the selected bit, so an RMW doubles as a test-and-set. Sits between a control FSM and local storage, e.g. flag tables and allocation bitmaps.

## Interface
- DATA_WIDTH, 8, word width in bits; power of two, 2..64
- ADDR_WIDTH, 11, word address width; depth = 2**ADDR_WIDTH
- BIT_WIDTH, $clog2(DATA_WIDTH), bit-index width; derived, not overridden

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  3  0=READ, 1=WRITE, 2=SET, 3=CLR, 4=TGL; 5..7 reserved
- cmd_addr  in  ADDR_WIDTH  word address
- cmd_bit  in  BIT_WIDTH  bit index for SET/CLR/TGL and for rd_bit
- cmd_data  in  DATA_WIDTH  write data, WRITE only
- rd_valid  out  1  one-cycle pulse: rd_data/rd_bit valid
- rd_data  out  DATA_WIDTH  addressed word, pre-modification for RMW ops
- rd_bit  out  1  rd_data[bit index of the command]
- cmd_err  out  1  one-cycle pulse: reserved opcode was accepted

## Operation
- FSM states: IDLE, WB (write-back).
- IDLE: cmd_ready=1.
  - READ: starts a synchronous memory read.
  - WRITE: writes cmd_data at the acceptance edge; no response.
  - SET/CLR/TGL: registers op, address and bit, starts the read, goes to WB.
  - Reserved opcode: accepted, memory untouched, cmd_err pulses next cycle, no rd_valid.
- WB: cmd_ready=0.
  - The read word is modified: SET → word | (1<<bit), CLR → word & ~(1<<bit), TGL → word ^ (1<<bit).
  - The modified word is written at the edge that ends WB, then the FSM returns to IDLE.
- rd_data is the word before modification; rd_bit is its selected bit.
- Memory contents are never reset and are undefined until written.
- rst clears only the FSM and the outputs.
- Address arithmetic is unsigned with no wrap handling needed: every ADDR_WIDTH value is a valid word.

## Timing
- Reset values: cmd_ready=1 (state IDLE); rd_valid=0, rd_data=0, rd_bit=0, cmd_err=0.
- READ accepted at edge N: rd_valid=1 between edges N+1 and N+2, then 0.
- Throughput: READ and WRITE 1 per cycle, back-to-back.
- RMW accepted at edge N:
  - rd_valid (old word) is high during the WB cycle, between edges N+1 and N+2.
  - The write commits at edge N+2; the next command can be accepted at edge N+2.
  - Throughput: 1 RMW per 2 cycles.
- Read-after-write, same address, consecutive cycles: the READ returns the newly written word. WRITE commits before the READ samples.
- An RMW followed by any command to the same address sees the modified word. cmd_ready blocks overlap, so no forwarding is needed.
- rd_data and rd_bit hold their last value while rd_valid=0.
- rst asserted in WB: write-back is aborted, memory is unchanged, state goes to IDLE, rd_valid=0 on the following cycle.
- cmd_valid with cmd_ready=0 has no effect. The requester must hold the command until it is accepted.

## Structure
- Shared package ram_bit_pkg holds:
  - opcode localparams OP_READ, OP_WRITE, OP_SET, OP_CLR, OP_TGL;
  - the state encoding (ST_IDLE, ST_WB);
  - a bit-modify function (word, bit, op) → word.
- One sub-module, ram_bit_sp_mem: plain single-port RAM with one write port and a synchronous registered read, inferable as block RAM.
- Top level holds the FSM, command registers and output registers.

## Test plan
- Reset, then WRITE addr 0..10 with data 1..11, then READ addr 0..10 back-to-back → rd_data 1..11 on consecutive cycles, each one cycle after its READ.
- WRITE addr 5 = 8'h00, then SET bit 3 → rd_data=8'h00, rd_bit=0, cmd_ready low for one cycle. READ addr 5 → 8'h08, rd_bit(bit 3)=1.
- Addr 5 = 8'hFF:
  - CLR bit 7 → returns 8'hFF, memory becomes 8'h7F;
  - then TGL bit 0 → returns 8'h7F, memory becomes 8'h7E;
  - READ → 8'h7E.
- DATA_WIDTH=32, ADDR_WIDTH=4:
  - WRITE addr 15 = 32'h8000_0001;
  - SET bit 31 twice → second returns rd_bit=1, memory unchanged;
  - TGL bit 16 → READ returns 32'h8001_0001.
- Addr 2 = 8'hAA. SET bit 0 accepted, rst asserted in the WB cycle → cmd_ready=1 and rd_valid=0 after reset. READ addr 2 → 8'hAA, write-back aborted.
- cmd_op=6 at addr 3 → cmd_err pulses once, no rd_valid, READ addr 3 returns its previous value. WRITE then READ of addr 4 on consecutive cycles → the READ returns the new value.
